// File: rtl/lcd_command_sequencer.sv
// Power-on init and 2x16 line refresh sequencer for an ST7032-class I2C LCD.
// Optional NACK retry is enabled by defining NACK_RETRY_EN.
module lcd_command_sequencer #(
  parameter logic [7:0] SLAVE_ADDR     = 8'h7C,
  parameter int         PWR_DLY_CYC    = 4_000_000,
  parameter int         CMD_DLY_CYC    = 3_000,
  parameter int         FOLLOW_DLY_CYC = 20_000_000,
  parameter int         CLR_DLY_CYC    = 110_000,
  parameter int         DLY_W          = 25,
  parameter int         MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_low,
  input  logic       buf_we,
  input  logic [4:0] buf_addr,
  input  logic [7:0] buf_data,
  input  logic       refresh,
  output logic       m_valid,
  output logic [7:0] m_byte,
  output logic       m_start,
  output logic       m_stop,
  input  logic       m_ready,
  input  logic       m_done,
  input  logic       m_nack,
  output logic       busy,
  output logic       init_done,
  output logic       err
);
  // state      | meaning
  // PWR_WAIT   | power-up delay after reset
  // INIT_TX    | sending one init command transaction
  // INIT_WAIT  | post-command delay
  // IDLE       | waiting for a refresh request
  // LINE_TX    | sending one display line
  // LINE_WAIT  | post-line delay
  // RETRY_WAIT | delay before resending a NACKed transaction
  // ERR        | aborted, left only by reset
  typedef enum logic [2:0] {
    S_PWR_WAIT, S_INIT_TX, S_INIT_WAIT, S_IDLE,
    S_LINE_TX, S_LINE_WAIT, S_RETRY_WAIT, S_ERR
  } state_t;

  localparam logic [DLY_W-1:0] PWR_TC    = DLY_W'(PWR_DLY_CYC - 1);
  localparam logic [DLY_W-1:0] CMD_TC    = DLY_W'(CMD_DLY_CYC - 1);
  localparam logic [DLY_W-1:0] FOLLOW_TC = DLY_W'(FOLLOW_DLY_CYC - 1);
  localparam logic [DLY_W-1:0] CLR_TC    = DLY_W'(CLR_DLY_CYC - 1);

  function automatic logic [7:0] init_cmd(input logic [3:0] idx);
    case (idx)
      4'd0:    init_cmd = 8'h38;
      4'd1:    init_cmd = 8'h39;
      4'd2:    init_cmd = 8'h14;
      4'd3:    init_cmd = 8'h70;
      4'd4:    init_cmd = 8'h56;
      4'd5:    init_cmd = 8'h6C;
      4'd6:    init_cmd = 8'h38;
      4'd7:    init_cmd = 8'h0C;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  logic [DLY_W-1:0] r_cnt, w_tc;
  logic [3:0]       r_idx;
  logic             r_line, r_out, r_pend;
  logic [4:0]       r_pos;
  logic [7:0]       r_buf [32];
  logic [7:0]       w_cmd, w_byte;
  logic [3:0]       w_col;
  logic             w_done, w_last, w_dly_end, w_tx, w_nack_err;

  assign w_cmd     = init_cmd(r_idx);
  assign w_done    = r_out & m_done;
  assign w_tx      = (r_state == S_INIT_TX) || (r_state == S_LINE_TX);
  assign w_last    = (r_state == S_INIT_TX) ? (r_pos == 5'd2) : (r_pos == 5'd19);
  assign w_dly_end = (r_cnt == w_tc);
  assign w_col     = r_pos[3:0] - 4'd4;

`ifdef NACK_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] r_retry;

  assign w_nack_err = (r_retry == RW'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_low) begin
    if (!rst_low)
      r_retry <= '0;
    else if (w_done && m_nack)
      r_retry <= r_retry + 1'b1;
    else if (w_done && w_last)
      r_retry <= '0;
  end
`else
  assign w_nack_err = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_low) begin
    if (!rst_low) r_state <= S_PWR_WAIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PWR_WAIT:   if (w_dly_end) w_state_nxt = S_INIT_TX;
      S_INIT_TX, S_LINE_TX: begin
        if (w_done) begin
          if (m_nack)      w_state_nxt = w_nack_err ? S_ERR : S_RETRY_WAIT;
          else if (w_last) w_state_nxt = (r_state == S_INIT_TX) ? S_INIT_WAIT : S_LINE_WAIT;
        end
      end
      S_INIT_WAIT:  if (w_dly_end) w_state_nxt = (r_idx == 4'd8) ? S_IDLE : S_INIT_TX;
      S_IDLE:       if (r_pend) w_state_nxt = S_LINE_TX;
      S_LINE_WAIT:  if (w_dly_end) w_state_nxt = r_line ? S_IDLE : S_LINE_TX;
      S_RETRY_WAIT: if (w_dly_end) w_state_nxt = init_done ? S_LINE_TX : S_INIT_TX;
      default:      w_state_nxt = S_ERR;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE) && (r_state != S_ERR);
    case (r_state)
      S_PWR_WAIT:  w_tc = PWR_TC;
      S_INIT_WAIT: w_tc = (w_cmd == 8'h6C) ? FOLLOW_TC : (w_cmd == 8'h01) ? CLR_TC : CMD_TC;
      default:     w_tc = CMD_TC;
    endcase
    w_byte = SLAVE_ADDR;
    if (r_pos != 5'd0) begin
      if (r_state == S_INIT_TX)
        w_byte = (r_pos == 5'd1) ? 8'h00 : w_cmd;
      else begin
        case (r_pos)
          5'd1:    w_byte = 8'h80;
          5'd2:    w_byte = {1'b1, r_line, 6'b0};
          5'd3:    w_byte = 8'h40;
          default: w_byte = r_buf[{r_line, w_col}];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_low) begin
    if (!rst_low) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_line    <= 1'b0;
      r_pos     <= '0;
      r_out     <= 1'b0;
      r_pend    <= 1'b0;
      m_valid   <= 1'b0;
      m_byte    <= 8'h00;
      m_start   <= 1'b0;
      m_stop    <= 1'b0;
      init_done <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
    end else begin
      if (buf_we) r_buf[buf_addr] <= buf_data;
      // a refresh landing on the same edge as the clear must not be lost
      if (refresh)
        r_pend <= 1'b1;
      else if (r_state == S_IDLE && w_state_nxt == S_LINE_TX)
        r_pend <= 1'b0;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
        r_pos <= '0;
      end else begin
        r_cnt <= r_cnt + DLY_W'(1);
        if (w_done && !m_nack) r_pos <= r_pos + 5'd1;
      end
      if (r_state == S_INIT_WAIT && w_state_nxt == S_INIT_TX) r_idx <= r_idx + 4'd1;
      if (r_state == S_IDLE && w_state_nxt == S_LINE_TX) r_line <= 1'b0;
      else if (r_state == S_LINE_WAIT && w_state_nxt == S_LINE_TX) r_line <= 1'b1;
      if (r_state == S_INIT_WAIT && w_state_nxt == S_IDLE) init_done <= 1'b1;
      if (w_state_nxt == S_ERR) err <= 1'b1;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        r_out   <= 1'b1;
      end else if (w_done) begin
        r_out <= 1'b0;
      end else if (w_tx && !m_valid && !r_out) begin
        m_valid <= 1'b1;
        m_byte  <= w_byte;
        m_start <= (r_pos == 5'd0);
        m_stop  <= w_last;
      end
    end
  end
endmodule

// File: tb/tb_lcd_command_sequencer.sv
// Scoreboard bench: random-latency I2C master model, reference byte lists built from the LCD protocol.
module tb_lcd_command_sequencer;
  localparam int PWR = 40, CMD = 10, FOL = 20, CLR = 30;

  logic clk, rst_low, buf_we, refresh, m_valid, m_start, m_stop;
  logic m_ready, m_done, m_nack, busy, init_done, err;
  logic [4:0] buf_addr;
  logic [7:0] buf_data, m_byte;

  lcd_command_sequencer #(
    .SLAVE_ADDR(8'h7C), .PWR_DLY_CYC(PWR), .CMD_DLY_CYC(CMD), .FOLLOW_DLY_CYC(FOL),
    .CLR_DLY_CYC(CLR), .DLY_W(25), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_low(rst_low), .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .refresh(refresh), .m_valid(m_valid), .m_byte(m_byte), .m_start(m_start), .m_stop(m_stop),
    .m_ready(m_ready), .m_done(m_done), .m_nack(m_nack), .busy(busy), .init_done(init_done),
    .err(err)
  );

  typedef struct { logic [7:0] b; logic s; logic p; int gap; } item_t;
  item_t exp_q[$];
  logic [7:0] shadow [32];
  int n_cmp = 0, n_bad = 0;
  int nack_left = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] rom_at(input int i);
    case (i)
      0: return 8'h38; 1: return 8'h39; 2: return 8'h14; 3: return 8'h70;
      4: return 8'h56; 5: return 8'h6C; 6: return 8'h38; 7: return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  function automatic int dly_of(input logic [7:0] c);
    if (c == 8'h6C) return FOL;
    if (c == 8'h01) return CLR;
    return CMD;
  endfunction

  function automatic void push(input logic [7:0] b, input logic s, input logic p, input int gap);
    item_t it;
    it.b = b; it.s = s; it.p = p; it.gap = gap;
    exp_q.push_back(it);
  endfunction

  // gap: cycles from the consuming edge of the previous m_done to the rise of m_valid
  function automatic void push_init(input int nack_entry, input int nacks, input bit abort);
    int g = -1;
    for (int i = 0; i < 9; i++) begin
      if (i == nack_entry) begin
        for (int k = 0; k < nacks; k++) begin
          push(8'h7C, 1'b1, 1'b0, g);
          push(8'h00, 1'b0, 1'b0, -1);
          g = CMD + 1;
        end
        if (abort) return;
      end
      push(8'h7C, 1'b1, 1'b0, g);
      push(8'h00, 1'b0, 1'b0, -1);
      push(rom_at(i), 1'b0, 1'b1, -1);
      g = dly_of(rom_at(i)) + 1;
    end
  endfunction

  function automatic void push_refresh();
    for (int ln = 0; ln < 2; ln++) begin
      push(8'h7C, 1'b1, 1'b0, (ln == 0) ? -1 : CMD + 1);
      push(8'h80, 1'b0, 1'b0, -1);
      push((ln == 0) ? 8'h80 : 8'hC0, 1'b0, 1'b0, -1);
      push(8'h40, 1'b0, 1'b0, -1);
      for (int c = 0; c < 16; c++) push(shadow[ln*16 + c], 1'b0, (c == 15), -1);
    end
  endfunction

  // master model and monitor share one negedge process
  int n = 0, last_done_n = 0, rise_n = 0, lat = 0, tpos = 0, completed = 0;
  bit outstanding = 0, valid_prev = 0, acc_prev = 0, idone_prev = 0, cur_nack = 0, cur_stop = 0, acc;
  logic [7:0] byte_prev;
  logic start_prev, stop_prev;

  initial begin
    item_t it;
    m_ready = 1'b0; m_done = 1'b0; m_nack = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      m_done = 1'b0; m_nack = 1'b0;
      if (!rst_low) begin
        outstanding = 0; valid_prev = 0; acc_prev = 0; idone_prev = 0;
        completed = 0; m_ready = 1'b0; last_done_n = n; rise_n = n;
      end else begin
        if (acc_prev) chk("valid_drop_after_accept", m_valid, 0);
        else if (valid_prev) begin
          chk("valid_held", m_valid, 1);
          chk("fields_held", {m_byte, m_start, m_stop}, {byte_prev, start_prev, stop_prev});
        end
        if (outstanding && !acc_prev) chk("valid_while_outstanding", m_valid, 0);
        if (m_valid && !valid_prev) rise_n = n;
        if (init_done && !idone_prev) begin
          chk("init_done_delay", n - last_done_n, CLR);
          chk("busy_at_init_done", busy, 0);
        end
        if (outstanding) begin
          if (lat == 0) begin
            m_done = 1'b1; m_nack = cur_nack; outstanding = 0; last_done_n = n + 1;
            if (cur_stop && !cur_nack) completed++;
          end else lat--;
        end else if ($urandom_range(0, 9) == 0) begin
          m_done = 1'b1;
          m_nack = 1'($urandom_range(0, 1));
        end
        m_ready = ($urandom_range(0, 3) != 0);
        acc = m_valid && m_ready && !outstanding;
        if (acc) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_byte: got %02h, expected no byte", m_byte);
          end else begin
            it = exp_q.pop_front();
            chk("byte", m_byte, it.b);
            chk("start_flag", m_start, it.s);
            chk("stop_flag", m_stop, it.p);
            if (it.gap >= 0) chk("inter_tx_delay", rise_n - last_done_n, it.gap);
          end
          tpos = m_start ? 0 : tpos + 1;
          cur_nack = (tpos == 1 && completed == 3 && nack_left > 0);
          if (cur_nack) nack_left--;
          cur_stop = m_stop; outstanding = 1; lat = $urandom_range(0, 3);
        end
        valid_prev = m_valid; byte_prev = m_byte; start_prev = m_start; stop_prev = m_stop;
        acc_prev = acc; idone_prev = init_done;
      end
    end
  end

  task automatic do_reset();
    rst_low = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
    nack_left = 0;
    #2 rst_low = 1'b1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    shadow[a] = d;
    @(negedge clk); buf_we = 1'b1; buf_addr = a; buf_data = d;
    @(negedge clk); buf_we = 1'b0;
  endtask

  task automatic pulse_refresh();
    @(negedge clk); refresh = 1'b1;
    @(negedge clk); refresh = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    chk("idle_reached", ok, 1);
  endtask

  task automatic wait_q(input int thr);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_valid && exp_q.size() <= thr) begin ok = 1; break; end
    end
    chk("queue_progress", ok, 1);
  endtask

  task automatic check_err_quiet();
    bit ok = 0, saw_valid = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (err) begin ok = 1; break; end
    end
    chk("err_reached", ok, 1);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_valid) saw_valid = 1;
    end
    chk("err_no_valid", saw_valid, 0);
    chk("err_sticky", err, 1);
    chk("err_init_done", init_done, 0);
    chk("err_busy", busy, 0);
    chk("err_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    buf_we = 1'b0; buf_addr = '0; buf_data = '0; refresh = 1'b0;
    rst_low = 1'b1;
    #1 rst_low = 1'b0;
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_byte", m_byte, 0);
    chk("rst_m_start_stop", {m_start, m_stop}, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    chk("rst_err", err, 0);

    do_reset();
    push_init(-1, 0, 0);
    wait_idle(5000);
    chk("init_done_set", init_done, 1);
    chk("init_err_clear", err, 0);

    wr(5'd0, 8'h48); wr(5'd1, 8'h45); wr(5'd2, 8'h4C); wr(5'd3, 8'h4C); wr(5'd4, 8'h4F);
    push_refresh();
    pulse_refresh();
    wait_idle(3000);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 6; k++) wr(5'($urandom_range(0, 31)), 8'($urandom_range(32, 126)));
      push_refresh();
      pulse_refresh();
      wait_idle(3000);
    end

    // two refreshes during line 0, plus a write to an already-sent column
    push_refresh();
    pulse_refresh();
    wait_q(30);
    wr(5'd0, 8'h5A);
    pulse_refresh();
    pulse_refresh();
    push_refresh();
    wait_idle(6000);
    repeat (200) @(negedge clk);
    chk("no_extra_rewrite", exp_q.size(), 0);
    chk("idle_after_double", busy, 0);

    push_refresh();
    pulse_refresh();
    wait_q(35);
    #2 rst_low = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_busy", busy, 1);
    chk("async_rst_init_done", init_done, 0);
    do_reset();
    push_init(-1, 0, 0);
    push_refresh();
    pulse_refresh();
    wait_idle(8000);
    chk("post_reset_init_done", init_done, 1);

`ifdef NACK_RETRY_EN
    do_reset();
    nack_left = 2;
    push_init(3, 2, 0);
    wait_idle(8000);
    chk("retry_init_done", init_done, 1);
    chk("retry_err", err, 0);
    chk("retry_nacks_used", nack_left, 0);
    do_reset();
    nack_left = 4;
    push_init(3, 4, 1);
    check_err_quiet();
`else
    do_reset();
    nack_left = 1;
    push_init(3, 1, 1);
    check_err_quiet();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lcd_command_sequencer.md
Name: lcd_command_sequencer

Overview:
Sequences all traffic to the two-line I2C character LCD (ST7032-class controller, slave address 0x7C) through the byte-level I2C master. Runs the power-on init command list with the required inter-command delays, then holds a 2x16 character shadow buffer. On request, it rewrites both display lines as I2C transactions. Sits between the top-level/host logic and the bit-level I2C driver; owns the driver exclusively.

Parameters:
SLAVE_ADDR, 8'h7C, 8-bit write address byte (R/W=0 included)
PWR_DLY_CYC, 4_000_000, clk cycles waited after reset release before the first transaction (40 ms @100 MHz)
CMD_DLY_CYC, 3_000, cycles after each ordinary init command
FOLLOW_DLY_CYC, 20_000_000, cycles after follower-control command 0x6C
CLR_DLY_CYC, 110_000, cycles after clear-display 0x01
DLY_W, 25, delay counter width; must hold the largest delay
MAX_RETRY, 3, retries per transaction (NACK_RETRY_EN only)

Ports:
clk  in  1  system clock
rst_low  in  1  asynchronous active-low reset
buf_we  in  1  shadow-buffer write strobe
buf_addr  in  5  [4]=line, [3:0]=column
buf_data  in  8  character code
refresh  in  1  single-cycle request to rewrite both lines
m_valid  out  1  byte request to I2C master
m_byte  out  8  byte to send
m_start  out  1  generate START before this byte
m_stop  out  1  generate STOP after this byte
m_ready  in  1  master accepts the request (m_valid & m_ready)
m_done  in  1  single-cycle pulse: byte and ACK slot finished
m_nack  in  1  qualified by m_done; slave NACKed
busy  out  1  transaction or delay in progress
init_done  out  1  init list completed successfully
err  out  1  sticky; transaction aborted

Behaviour:
- Reset (async assert, sync release): state PWR_WAIT, delay counter=0, m_valid=0, m_byte=0, m_start=0, m_stop=0, busy=1, init_done=0, err=0, refresh_pend=0, retry count=0, all 32 buffer bytes=8'h20.
- Init list (9 entries, fixed ROM): 38,39,14,70,56,6C,38,0C,01. Each entry forms one transaction: [START]SLAVE_ADDR, 0x00, cmd[STOP].
- States:
  - PWR_WAIT: count PWR_DLY_CYC, then go to INIT_TX with index 0.
  - INIT_TX: issue the 3 bytes, then go to INIT_WAIT.
  - INIT_WAIT: wait for the per-command delay. Use FOLLOW_DLY_CYC for 0x6C, CLR_DLY_CYC for 0x01, and CMD_DLY_CYC otherwise. At index 8, go to IDLE and set init_done=1. Otherwise increment index and return to INIT_TX.
  - IDLE: busy=0. If refresh_pend is set, go to LINE_TX with line=0.
  - LINE_TX: issue 20 bytes in one transaction: [START]SLAVE_ADDR, 0x80, 0x80|(line?0x40:0x00), 0x40, then buf[line][0..15], with m_stop on the last byte. Then go to LINE_WAIT.
  - LINE_WAIT: wait CMD_DLY_CYC. If line=0, set line=1 and return to LINE_TX. Otherwise go to IDLE.
  - ERR: m_valid=0, busy=0. Leave only on reset.
- Byte handshake:
  - Assert m_valid with m_byte/m_start/m_stop stable until accepted.
  - Drop m_valid the cycle after acceptance.
  - Do not present the next byte until m_done has been seen.
  - Ignore m_done while no byte is outstanding.
- m_done with m_nack=1: the master finishes with STOP; the sequencer goes to ERR and sets err=1 (see Optional Feature).
- refresh: sets refresh_pend in any state. Clear refresh_pend when LINE_TX is entered with line=0. A refresh arriving mid-refresh therefore causes exactly one extra full rewrite. Before init_done, the refresh is held pending and serviced after init.
- Buffer writes:
  - Accepted every cycle in every state.
  - A byte is read from the buffer on the cycle it is presented.
  - A write to a location already presented takes effect on the next refresh only.
  - A write and a read of the same address in the same cycle presents the old value.
- Delay counters load 0 and count up to N-1, so the delay lasts exactly N cycles. N=0 is not supported.
- busy=1 in every state except IDLE and ERR.

Optional Feature:
NACK_RETRY_EN.
- Defined: on NACK, wait CMD_DLY_CYC, then restart the current transaction from its first byte. Restart means the same init index, or the same line. A retry counter is kept per transaction and cleared on success. Go to ERR on the (MAX_RETRY+1)-th NACK.
- Undefined: the first NACK goes straight to ERR. No retry counter exists.

Test Plan:
- Reset release with master always ready and ACKing, delays scaled to 10/20/30/40 -> exactly 27 bytes in 9 START..STOP groups in order 7C,00,38 ... 7C,00,01; init_done rises 30 cycles after the last m_done; busy falls at the same edge.
- buf writes "HELLO" to line 0, columns 0..4, then refresh -> 7C,80,80,40,48,45,4C,4C,4F then eleven 20 with STOP on the last; then 7C,80,C0,40 followed by sixteen 20.
- refresh pulsed twice during line-0 transfer -> exactly two complete 2-line rewrites, then IDLE.
- NACK on the 2nd byte of init entry 3, macro off -> err=1, m_valid stays 0, and init_done stays 0 through 1000 cycles and until reset.
- Same NACK with NACK_RETRY_EN, MAX_RETRY=3: NACK 2 times then ACK -> entry 3 is resent from 7C and init completes with err=0. NACK 4 times -> err=1.
- rst_low asserted mid-LINE_TX with m_valid high -> m_valid=0 immediately (async); after release, PWR_WAIT restarts and buffer bytes read back as 20.
